fifo_key_packer: RTL and testbench



---
 rtl/fifo_key_packer.sv | 126 ++++++++++++
 tb/tb_fifo_key_packer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_key_packer.sv
// Pops keys from the async FIFO read port and packs WAYS consecutive keys into
// one block on a valid/ready interface; flush pads a partial block with all-ones.
module fifo_key_packer #(
    parameter int KEYW = 32,
    parameter int WAYS = 8,
    parameter int CNTW = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [KEYW-1:0]      din,
    input  logic                 din_empty,
    output logic                 din_deq,
    input  logic                 flush,
    output logic [KEYW*WAYS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [CNTW-1:0]      blk_cnt
);
    localparam int CW  = $clog2(WAYS + 1);
    localparam int CW1 = CW + 1;
    localparam logic [CW-1:0]   FULL_C    = CW'(WAYS);
    localparam logic [CW:0]     FULL_O    = CW1'(WAYS);
    localparam logic [CW-1:0]   ONE_C     = CW'(1);
    localparam logic [CNTW-1:0] CNT_ONE_C = CNTW'(1);

    logic [KEYW*WAYS-1:0] pack_r;
    logic [KEYW*WAYS-1:0] dout_r;
    logic [CW-1:0]        count_r;
    logic [CW-1:0]        count_nxt_s;
    logic [CW-1:0]        base_s;
    logic [CW:0]          occ_s;
    logic                 pending_r;
    logic                 flush_pend_r;
    logic                 flush_pend_nxt_s;
    logic                 dout_valid_r;
    logic                 dout_valid_nxt_s;
    logic [CNTW-1:0]      blk_cnt_r;
    logic                 transfer_s;
    logic                 accept_s;
    logic                 pad_s;

    // Transfer/handshake decode, FIFO read strobe and next-state values
    always_comb begin
        accept_s   = dout_valid_r && dout_ready;
        transfer_s = (count_r == FULL_C) && (!dout_valid_r || dout_ready);
        // count never exceeds WAYS and is never full while a key is in flight
        pad_s      = flush_pend_r && !pending_r && (count_r != '0) && (count_r != FULL_C);
        base_s     = transfer_s ? '0 : count_r;
        occ_s      = {1'b0, base_s} + {{CW{1'b0}}, pending_r};
        din_deq    = !RST && !din_empty && !flush_pend_r && (occ_s < FULL_O);

        if (pending_r) begin
            count_nxt_s = base_s + ONE_C;
        end else if (pad_s) begin
            count_nxt_s = FULL_C;
        end else begin
            count_nxt_s = base_s;
        end

        if (flush_pend_r) begin
            if (transfer_s || ((count_r == '0) && !pending_r)) begin
                flush_pend_nxt_s = 1'b0;
            end else begin
                flush_pend_nxt_s = 1'b1;
            end
        end else begin
            flush_pend_nxt_s = flush;
        end

        if (transfer_s) begin
            dout_valid_nxt_s = 1'b1;
        end else if (accept_s) begin
            dout_valid_nxt_s = 1'b0;
        end else begin
            dout_valid_nxt_s = dout_valid_r;
        end
    end

    // Control state and accepted-block counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_r      <= '0;
            pending_r    <= 1'b0;
            flush_pend_r <= 1'b0;
            dout_valid_r <= 1'b0;
            blk_cnt_r    <= '0;
        end else begin
            count_r      <= count_nxt_s;
            pending_r    <= din_deq;
            flush_pend_r <= flush_pend_nxt_s;
            dout_valid_r <= dout_valid_nxt_s;
            if (accept_s) begin
                blk_cnt_r <= blk_cnt_r + CNT_ONE_C;
            end
        end
    end

    // Pack buffer: arriving key lands in lane base_s, flush fills the tail with sentinels
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pack_r <= '0;
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                if (pad_s && (CW'(i) >= count_r)) begin
                    pack_r[i*KEYW +: KEYW] <= {KEYW{1'b1}};
                end else if (pending_r && (CW'(i) == base_s)) begin
                    pack_r[i*KEYW +: KEYW] <= din;
                end
            end
        end
    end

    // Output block register: loads on transfer, otherwise held stable
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_r <= '0;
        end else if (transfer_s) begin
            dout_r <= pack_r;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign blk_cnt    = blk_cnt_r;

endmodule

// File: tb/tb_fifo_key_packer.sv
// Self-checking bench for fifo_key_packer: a queue-based FIFO model feeds keys and
// a key-stream reference model (keys chunked into blocks, flush padding) checks the output.
module tb_fifo_key_packer;
    localparam int KEYW = 32;
    localparam int WAYS = 8;
    localparam int CNTW = 32;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [KEYW-1:0]      din;
    logic                 din_empty;
    logic                 din_deq;
    logic                 flush;
    logic [KEYW*WAYS-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic [CNTW-1:0]      blk_cnt;

    fifo_key_packer #(.KEYW(KEYW), .WAYS(WAYS), .CNTW(CNTW)) dut (
        .CLK(CLK), .RST(RST), .din(din), .din_empty(din_empty), .din_deq(din_deq),
        .flush(flush), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .blk_cnt(blk_cnt)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    logic [KEYW-1:0]      fifo_q[$];
    logic [KEYW-1:0]      exp_q[$];
    logic [KEYW*WAYS-1:0] acc_q[$];
    int                   acc_cyc_q[$];
    bit                   deq_hist[$];
    int                   cyc;
    int                   ready_pct;
    int                   empty_pct;
    bit                   flush_req;
    int                   stream_n;
    int                   hold_viol;
    int                   deq_empty_viol;
    bit                   hold_prev;
    logic [KEYW*WAYS-1:0] hold_dout;

    task automatic do_reset();
        RST = 1'b1; flush = 1'b0; din_empty = 1'b1; dout_ready = 1'b0; din = '0;
        fifo_q.delete(); exp_q.delete(); acc_q.delete(); acc_cyc_q.delete(); deq_hist.delete();
        stream_n = 0; hold_prev = 1'b0; hold_viol = 0; deq_empty_viol = 0;
        flush_req = 1'b0; cyc = 0; ready_pct = 100; empty_pct = 0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic push_key(input logic [KEYW-1:0] k);
        fifo_q.push_back(k);
        exp_q.push_back(k);
        stream_n++;
    endtask

    // reference model of flush: pad the open block of the key stream with sentinels
    task automatic model_flush();
        int pad;
        pad = (WAYS - (stream_n % WAYS)) % WAYS;
        repeat (pad) exp_q.push_back({KEYW{1'b1}});
        stream_n += pad;
        flush_req = 1'b1;
    endtask

    // one clock cycle: drive inputs at negedge, observe, then FIFO delivers popped key
    task automatic step();
        bit deq_s;
        dout_ready = ($urandom_range(99, 0) < ready_pct);
        din_empty  = (fifo_q.size() == 0) || ($urandom_range(99, 0) < empty_pct);
        flush      = flush_req;
        flush_req  = 1'b0;
        #1;
        deq_s = din_deq;
        if (deq_s && din_empty) deq_empty_viol++;
        if (hold_prev && (dout !== hold_dout)) hold_viol++;
        hold_prev = dout_valid && !dout_ready;
        hold_dout = dout;
        if (dout_valid && dout_ready) begin
            acc_q.push_back(dout);
            acc_cyc_q.push_back(cyc);
        end
        deq_hist.push_back(deq_s);
        @(posedge CLK);
        #1;
        if (deq_s && (fifo_q.size() > 0)) din = fifo_q.pop_front();
        else din = $urandom;
        cyc++;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; din_empty = 1'b0; dout_ready = 1'b1; flush = 1'b0; din = '0;
        repeat (2) @(negedge CLK);
        #1;
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", dout_valid); end
        n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL reset_dout got %h want 0", dout); end
        n_cmp++; if (blk_cnt !== '0) begin n_err++; $display("FAIL reset_blk_cnt got %0d want 0", blk_cnt); end
        n_cmp++; if (din_deq !== 1'b0) begin n_err++; $display("FAIL reset_deq got %b want 0", din_deq); end
    endtask

    task automatic test_basic();
        logic [23:0] got_v, exp_v;
        logic [KEYW*WAYS-1:0] exp_blk;
        do_reset();
        for (int k = 1; k <= 16; k++) push_key(k);
        repeat (24) step();
        for (int i = 0; i < 24; i++) begin
            got_v[i] = deq_hist[i];
            exp_v[i] = (i < 8) || ((i >= 9) && (i < 17));
        end
        n_cmp++; if (got_v !== exp_v) begin n_err++; $display("FAIL basic_deq_pattern got %b want %b", got_v, exp_v); end
        n_cmp++; if (acc_q.size() != 2) begin n_err++; $display("FAIL basic_nblk got %0d want 2", acc_q.size()); end
        for (int b = 0; b < acc_q.size(); b++) begin
            for (int i = 0; i < WAYS; i++) begin
                if (exp_q.size() > 0) exp_blk[i*KEYW +: KEYW] = exp_q.pop_front();
                else exp_blk[i*KEYW +: KEYW] = '0;
            end
            n_cmp++; if (acc_q[b] !== exp_blk) begin n_err++; $display("FAIL basic_blk%0d got %h want %h", b, acc_q[b], exp_blk); end
        end
        n_cmp++; if (blk_cnt !== 32'd2) begin n_err++; $display("FAIL basic_blk_cnt got %0d want 2", blk_cnt); end
    endtask

    task automatic test_backpressure();
        logic [KEYW*WAYS-1:0] exp_blk;
        logic [KEYW*WAYS-1:0] first_blk;
        do_reset();
        ready_pct = 0;
        for (int k = 0; k < 24; k++) push_key(32'h200 + k);
        for (int i = 0; i < WAYS; i++) first_blk[i*KEYW +: KEYW] = 32'h200 + i;
        repeat (20) step();
        n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_held got %b want 1", dout_valid); end
        n_cmp++; if (dout !== first_blk) begin n_err++; $display("FAIL bp_dout_held got %h want %h", dout, first_blk); end
        n_cmp++; if ({deq_hist[17], deq_hist[18], deq_hist[19]} !== 3'b000) begin
            n_err++; $display("FAIL bp_deq_stall got %b want 000", {deq_hist[17], deq_hist[18], deq_hist[19]}); end
        n_cmp++; if (fifo_q.size() != 8) begin n_err++; $display("FAIL bp_fifo_left got %0d want 8", fifo_q.size()); end
        ready_pct = 100;
        repeat (25) step();
        n_cmp++; if (hold_viol !== 0) begin n_err++; $display("FAIL bp_hold_stable got %0d want 0", hold_viol); end
        n_cmp++; if (acc_q.size() != 3) begin n_err++; $display("FAIL bp_nblk got %0d want 3", acc_q.size()); end
        if (acc_cyc_q.size() >= 2) begin
            n_cmp++; if (acc_cyc_q[1] - acc_cyc_q[0] != 1) begin
                n_err++; $display("FAIL bp_b2b got %0d want 1", acc_cyc_q[1] - acc_cyc_q[0]); end
        end
        for (int b = 0; b < acc_q.size(); b++) begin
            for (int i = 0; i < WAYS; i++) begin
                if (exp_q.size() > 0) exp_blk[i*KEYW +: KEYW] = exp_q.pop_front();
                else exp_blk[i*KEYW +: KEYW] = '0;
            end
            n_cmp++; if (acc_q[b] !== exp_blk) begin n_err++; $display("FAIL bp_blk%0d got %h want %h", b, acc_q[b], exp_blk); end
        end
        n_cmp++; if (blk_cnt !== 32'd3) begin n_err++; $display("FAIL bp_blk_cnt got %0d want 3", blk_cnt); end
    endtask

    task automatic test_flush_pad();
        logic [KEYW*WAYS-1:0] exp_blk;
        do_reset();
        push_key(32'hA); push_key(32'hB); push_key(32'hC);
        repeat (6) step();
        model_flush();
        repeat (8) step();
        n_cmp++; if (acc_q.size() != 1) begin n_err++; $display("FAIL pad_nblk got %0d want 1", acc_q.size()); end
        n_cmp++; if (blk_cnt !== 32'd1) begin n_err++; $display("FAIL pad_blk_cnt got %0d want 1", blk_cnt); end
        for (int k = 0; k < 8; k++) push_key(32'h300 + k);
        repeat (14) step();
        n_cmp++; if (acc_q.size() != 2) begin n_err++; $display("FAIL pad_resume_nblk got %0d want 2", acc_q.size()); end
        for (int b = 0; b < acc_q.size(); b++) begin
            for (int i = 0; i < WAYS; i++) begin
                if (exp_q.size() > 0) exp_blk[i*KEYW +: KEYW] = exp_q.pop_front();
                else exp_blk[i*KEYW +: KEYW] = '0;
            end
            n_cmp++; if (acc_q[b] !== exp_blk) begin n_err++; $display("FAIL pad_blk%0d got %h want %h", b, acc_q[b], exp_blk); end
        end
    endtask

    task automatic test_flush_empty();
        logic [KEYW*WAYS-1:0] exp_blk;
        do_reset();
        model_flush();
        repeat (6) step();
        n_cmp++; if (acc_q.size() != 0) begin n_err++; $display("FAIL fe_nblk got %0d want 0", acc_q.size()); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL fe_valid got %b want 0", dout_valid); end
        n_cmp++; if (blk_cnt !== 32'd0) begin n_err++; $display("FAIL fe_blk_cnt got %0d want 0", blk_cnt); end
        ready_pct = 0;
        for (int k = 0; k < 16; k++) push_key(32'h400 + k);
        repeat (22) step();
        model_flush();
        step();
        ready_pct = 100;
        repeat (6) step();
        n_cmp++; if (blk_cnt !== 32'd2) begin n_err++; $display("FAIL fe_full_blk_cnt got %0d want 2", blk_cnt); end
        for (int k = 0; k < 8; k++) push_key(32'h480 + k);
        repeat (14) step();
        n_cmp++; if (acc_q.size() != 3) begin n_err++; $display("FAIL fe_full_nblk got %0d want 3", acc_q.size()); end
        for (int b = 0; b < acc_q.size(); b++) begin
            for (int i = 0; i < WAYS; i++) begin
                if (exp_q.size() > 0) exp_blk[i*KEYW +: KEYW] = exp_q.pop_front();
                else exp_blk[i*KEYW +: KEYW] = '0;
            end
            n_cmp++; if (acc_q[b] !== exp_blk) begin n_err++; $display("FAIL fe_blk%0d got %h want %h", b, acc_q[b], exp_blk); end
        end
    endtask

    task automatic test_async_reset();
        logic [KEYW*WAYS-1:0] exp_blk;
        do_reset();
        for (int k = 0; k < 8; k++) push_key(32'h500 + k);
        repeat (12) step();
        ready_pct = 0;
        for (int k = 0; k < 13; k++) push_key(32'h600 + k);
        repeat (16) step();
        n_cmp++; if (dout_valid !== 1'b1 || blk_cnt !== 32'd1) begin
            n_err++; $display("FAIL ar_pre got valid=%b cnt=%0d want valid=1 cnt=1", dout_valid, blk_cnt); end
        #2;
        RST = 1'b1;
        #1;
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got %b want 0", dout_valid); end
        n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL ar_dout got %h want 0", dout); end
        n_cmp++; if (blk_cnt !== '0) begin n_err++; $display("FAIL ar_blk_cnt got %0d want 0", blk_cnt); end
        n_cmp++; if (din_deq !== 1'b0) begin n_err++; $display("FAIL ar_deq got %b want 0", din_deq); end
        @(negedge CLK);
        RST = 1'b0;
        fifo_q.delete(); exp_q.delete(); acc_q.delete(); acc_cyc_q.delete();
        stream_n = 0; hold_prev = 1'b0; ready_pct = 100;
        for (int k = 100; k < 108; k++) push_key(k);
        repeat (12) step();
        n_cmp++; if (acc_q.size() != 1) begin n_err++; $display("FAIL ar_nblk got %0d want 1", acc_q.size()); end
        for (int b = 0; b < acc_q.size(); b++) begin
            for (int i = 0; i < WAYS; i++) begin
                if (exp_q.size() > 0) exp_blk[i*KEYW +: KEYW] = exp_q.pop_front();
                else exp_blk[i*KEYW +: KEYW] = '0;
            end
            n_cmp++; if (acc_q[b] !== exp_blk) begin n_err++; $display("FAIL ar_blk%0d got %h want %h", b, acc_q[b], exp_blk); end
        end
        n_cmp++; if (blk_cnt !== 32'd1) begin n_err++; $display("FAIL ar_blk_cnt got %0d want 1", blk_cnt); end
    endtask

    task automatic test_random();
        logic [KEYW*WAYS-1:0] exp_blk;
        int exp_nblk;
        do_reset();
        ready_pct = 50;
        empty_pct = 30;
        for (int k = 0; k < 1000; k++) push_key(k);
        for (int c = 0; (c < 20000) && (acc_q.size() < 1000 / WAYS); c++) step();
        ready_pct = 100;
        empty_pct = 0;
        model_flush();
        repeat (12) step();
        exp_nblk = stream_n / WAYS;
        n_cmp++; if (acc_q.size() != exp_nblk) begin n_err++; $display("FAIL rnd_nblk got %0d want %0d", acc_q.size(), exp_nblk); end
        n_cmp++; if (blk_cnt !== CNTW'(exp_nblk)) begin n_err++; $display("FAIL rnd_blk_cnt got %0d want %0d", blk_cnt, exp_nblk); end
        n_cmp++; if (deq_empty_viol !== 0) begin n_err++; $display("FAIL rnd_deq_on_empty got %0d want 0", deq_empty_viol); end
        n_cmp++; if (hold_viol !== 0) begin n_err++; $display("FAIL rnd_hold_stable got %0d want 0", hold_viol); end
        for (int b = 0; b < acc_q.size(); b++) begin
            for (int i = 0; i < WAYS; i++) begin
                if (exp_q.size() > 0) exp_blk[i*KEYW +: KEYW] = exp_q.pop_front();
                else exp_blk[i*KEYW +: KEYW] = '0;
            end
            n_cmp++; if (acc_q[b] !== exp_blk) begin n_err++; $display("FAIL rnd_blk%0d got %h want %h", b, acc_q[b], exp_blk); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush_pad();
        test_flush_empty();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
